// File: rtl/psram_resp_pkg.sv
// Shared opcodes, FSM state encoding and sizing constants for the QSPI PSRAM responder.
package psram_resp_pkg;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam int         ADDR_NIBBLES = 6;
    localparam int         CMD_BITS     = 8;
    localparam int         CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } psram_state_e;

    function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic low);
        return low ? b[3:0] : b[7:4];
    endfunction

endpackage

// File: rtl/psram_resp_sync.sv
// Two-flop synchronizers for the QSPI pads plus SCK edge and CE# falling-edge detection.
module psram_resp_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] io_in,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       ce_n_o,
    output logic       ce_fall_o,
    output logic [3:0] io_o
);

    logic       sck_meta_q, sck_sync_q, sck_prev_q;
    logic       ce_meta_q, ce_sync_q, ce_prev_q;
    logic [3:0] io_meta_q, io_sync_q;

    // CE# flops reset low so a reset taken mid-burst cannot fake a falling edge;
    // the burst in flight is then ignored until CE# really goes high and low again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            ce_meta_q  <= 1'b0;
            ce_sync_q  <= 1'b0;
            ce_prev_q  <= 1'b0;
            io_meta_q  <= 4'h0;
            io_sync_q  <= 4'h0;
        end else begin
            sck_meta_q <= sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            ce_meta_q  <= ce_n;
            ce_sync_q  <= ce_meta_q;
            ce_prev_q  <= ce_sync_q;
            io_meta_q  <= io_in;
            io_sync_q  <= io_meta_q;
        end
    end

    assign sck_rise_o = sck_sync_q & ~sck_prev_q;
    assign sck_fall_o = ~sck_sync_q & sck_prev_q;
    assign ce_n_o     = ce_sync_q;
    assign ce_fall_o  = ce_prev_q & ~ce_sync_q;
    assign io_o       = io_sync_q;

endmodule

// File: rtl/psram_resp.sv
// QSPI PSRAM responder: quad read (EB) / quad write (38) into a local byte memory.
// Define PSRAM_RESP_BKDR_EN to add the bd_* backdoor port set.
module psram_resp
    import psram_resp_pkg::*;
#(
    parameter int MEM_AW    = 10,
    parameter int DUMMY_CYC = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck,
    input  logic              ce_n,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic              busy,
    output logic              cmd_err,
`ifdef PSRAM_RESP_BKDR_EN
    input  logic              bd_we,
    input  logic [MEM_AW-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata,
`endif
    output psram_state_e      dbg_state_o
);

    logic             sck_rise, sck_fall, ce_n_s, ce_fall;
    logic [3:0]       io_s;

    psram_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       cmd_sr_q;
    logic [MEM_AW-1:0] addr_q;
    logic             is_write_q;
    logic             nib_q;
    logic [3:0]       wr_hi_q;
    logic [7:0]       wbyte_q;
    logic             we_q;
    logic [3:0]       io_out_q;
    logic [3:0]       io_oe_q;
    logic             cmd_err_q;
    logic [7:0]       opcode_d;

    logic [7:0]       mem [0:(1<<MEM_AW)-1];

    psram_resp_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck        (sck),
        .ce_n       (ce_n),
        .io_in      (io_in),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .ce_n_o     (ce_n_s),
        .ce_fall_o  (ce_fall),
        .io_o       (io_s)
    );

    assign opcode_d = {cmd_sr_q[6:0], io_s[0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_sr_q   <= 8'h00;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            nib_q      <= 1'b0;
            wr_hi_q    <= 4'h0;
            wbyte_q    <= 8'h00;
            we_q       <= 1'b0;
            io_out_q   <= 4'h0;
            io_oe_q    <= 4'h0;
            cmd_err_q  <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            we_q      <= 1'b0;
            // A completed write byte lands this clk; step past it.
            if (we_q) begin
                addr_q <= addr_q + MEM_AW'(1);
            end
            if (ce_n_s) begin
                // Deselect wins over any SCK edge seen in the same clk.
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                nib_q    <= 1'b0;
                io_oe_q  <= 4'h0;
                io_out_q <= 4'h0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ce_fall) begin
                            state_q <= ST_CMD;
                            cnt_q   <= '0;
                            nib_q   <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_sr_q <= opcode_d;
                            if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                                cnt_q <= '0;
                                if (opcode_d == CMD_QREAD) begin
                                    state_q    <= ST_ADDR;
                                    is_write_q <= 1'b0;
                                end else if (opcode_d == CMD_QWRITE) begin
                                    state_q    <= ST_ADDR;
                                    is_write_q <= 1'b1;
                                end else begin
                                    state_q   <= ST_IGNORE;
                                    cmd_err_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            // Upper address bits simply fall off the top of the shift.
                            addr_q <= MEM_AW'({addr_q, io_s});
                            if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
                                cnt_q <= '0;
                                nib_q <= 1'b0;
                                if (is_write_q) begin
                                    state_q <= ST_WDATA;
                                end else if (DUMMY_CYC == 0) begin
                                    state_q <= ST_RDATA;
                                end else begin
                                    state_q <= ST_DUMMY;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise) begin
                            if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                                cnt_q   <= '0;
                                state_q <= ST_RDATA;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sck_fall) begin
                            io_out_q <= pick_nibble(mem[addr_q], nib_q);
                            io_oe_q  <= 4'hF;
                            nib_q    <= ~nib_q;
                            if (nib_q) begin
                                addr_q <= addr_q + MEM_AW'(1);
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            nib_q <= ~nib_q;
                            if (!nib_q) begin
                                wr_hi_q <= io_s;
                            end else begin
                                wbyte_q <= {wr_hi_q, io_s};
                                we_q    <= 1'b1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Backdoor write is ordered last so it overrides a QSPI write to the same byte.
    always_ff @(posedge clk_i) begin
        if (we_q) begin
            mem[addr_q] <= wbyte_q;
        end
`ifdef PSRAM_RESP_BKDR_EN
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
`endif
    end

`ifdef PSRAM_RESP_BKDR_EN
    assign bd_rdata = mem[bd_addr];
`endif

    assign io_out      = io_out_q;
    assign io_oe       = io_oe_q;
    assign busy        = (state_q != ST_IDLE);
    assign cmd_err     = cmd_err_q;
    assign dbg_state_o = state_q;

endmodule
